// File: rtl/prf_freelist_ctrl_if.sv
// ---------------------------------------------------------------------------
// prf_freelist_ctrl_if
//   Port bundle between the free-list controller and the physical-register
//   free-list fifo (one write port, one read port).
//
//   wr_en / wdata : push one preg ID into the fifo
//   rd_en         : pop the head entry
//   rdata         : head entry, combinational from the fifo
//   full / empty  : fifo status
//   num           : fifo occupancy, NUM_WIDTH+1 bits
//
//   master : the controller (drives wr_en/wdata/rd_en)
//   slave  : the fifo
// ---------------------------------------------------------------------------
interface prf_freelist_ctrl_if #(
  parameter int PREG_WIDTH = 6,
  parameter int NUM_WIDTH  = 5
);
  logic                  wr_en;
  logic [PREG_WIDTH-1:0] wdata;
  logic                  rd_en;
  logic [PREG_WIDTH-1:0] rdata;
  logic                  full;
  logic                  empty;
  logic [NUM_WIDTH:0]    num;

  modport master (
    output wr_en, wdata, rd_en,
    input  rdata, full, empty, num
  );

  modport slave (
    input  wr_en, wdata, rd_en,
    output rdata, full, empty, num
  );
endinterface

// File: rtl/prf_freelist_ctrl.sv
// ---------------------------------------------------------------------------
// prf_freelist_ctrl
//   Sequencer/arbiter for the rename-stage physical-register free list.
//   After reset it loads FREE_INIT_NUM consecutive preg IDs starting at
//   FREE_INIT_BASE into the fifo, then serves allocation pops for rename and
//   merges two release sources (commit = rel0, squash = rel1) onto the single
//   fifo write port with round-robin arbitration.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset (shared with fifo)
//   flush_i              blocks allocation while high (releases continue)
//   alloc_req_i          rename requests one free preg
//   alloc_gnt_o          allocation granted this cycle
//   alloc_preg_o         granted preg ID (fifo head, zero latency)
//   rel0_valid_i/preg_i  commit-side release;  rel0_ready_o accepts it
//   rel1_valid_i/preg_i  squash-side release;  rel1_ready_o accepts it
//   init_done_o          registered; high once the free list is loaded
//   free_cnt_o           fifo occupancy pass-through
//   fifo_if              master side of the fifo port bundle
// ---------------------------------------------------------------------------
module prf_freelist_ctrl #(
  parameter int PREG_WIDTH     = 6,
  parameter int NUM_WIDTH      = 5,
  parameter int FREE_INIT_BASE = 32,
  parameter int FREE_INIT_NUM  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  alloc_req_i,
  output logic                  alloc_gnt_o,
  output logic [PREG_WIDTH-1:0] alloc_preg_o,
  input  logic                  rel0_valid_i,
  input  logic [PREG_WIDTH-1:0] rel0_preg_i,
  output logic                  rel0_ready_o,
  input  logic                  rel1_valid_i,
  input  logic [PREG_WIDTH-1:0] rel1_preg_i,
  output logic                  rel1_ready_o,
  output logic                  init_done_o,
  output logic [NUM_WIDTH:0]    free_cnt_o,
  prf_freelist_ctrl_if.master   fifo_if
);

  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  localparam logic [NUM_WIDTH:0] INIT_LAST = (NUM_WIDTH+1)'(FREE_INIT_NUM - 1);

  logic [0:0]            r_state;
  logic [NUM_WIDTH:0]    r_init_cnt;
  logic                  r_rr_ptr;     // 0: rel0 wins next tie, 1: rel1 wins
  logic                  r_init_done;

  logic                  w_init_wr;
  logic                  w_serving;
  logic                  w_alloc_gnt;
  logic                  w_elig0;
  logic                  w_elig1;
  logic                  w_both;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic [PREG_WIDTH-1:0] w_init_id;
  logic [PREG_WIDTH-1:0] w_wdata;

  // Base + count, truncated to the preg width.
  assign w_init_id = PREG_WIDTH'(FREE_INIT_BASE + int'(r_init_cnt));

  always_comb begin
    // NOTE: every combinational output is qualified with !rst, because the
    // reset state is INIT, which would otherwise assert fifo writes during reset.
    w_init_wr   = (r_state == S_INIT)  && !rst;
    w_serving   = (r_state == S_READY) && !rst;

    // No bypass: an empty fifo refuses allocation even if a release lands now.
    w_alloc_gnt = w_serving && alloc_req_i && !fifo_if.empty && !flush_i;

    // Full blocks releases even if an allocation pops in the same cycle.
    w_elig0     = w_serving && rel0_valid_i && !fifo_if.full;
    w_elig1     = w_serving && rel1_valid_i && !fifo_if.full;
    w_both      = w_elig0 && w_elig1;
    w_gnt0      = w_elig0 && (!w_elig1 || !r_rr_ptr);
    w_gnt1      = w_elig1 && (!w_elig0 ||  r_rr_ptr);

    w_wdata = '0;
    if (w_init_wr)   w_wdata = w_init_id;
    else if (w_gnt0) w_wdata = rel0_preg_i;
    else if (w_gnt1) w_wdata = rel1_preg_i;
  end

  assign alloc_gnt_o   = w_alloc_gnt;
  assign alloc_preg_o  = fifo_if.rdata;
  assign rel0_ready_o  = w_gnt0;
  assign rel1_ready_o  = w_gnt1;
  assign init_done_o   = r_init_done;
  assign free_cnt_o    = fifo_if.num;

  assign fifo_if.wr_en = w_init_wr || w_gnt0 || w_gnt1;
  assign fifo_if.wdata = w_wdata;
  assign fifo_if.rd_en = w_alloc_gnt;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_init_cnt  <= '0;
      r_rr_ptr    <= 1'b0;
      r_init_done <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
      if (r_init_cnt == INIT_LAST) begin
        r_state     <= S_READY;
        r_init_done <= 1'b1;
      end
    end else begin
      // Only a contested grant moves the pointer; it hands priority to the loser.
      if (w_both) r_rr_ptr <= ~r_rr_ptr;
    end
  end

endmodule
